fc_neuron_seq_mac: RTL

//  Parametrised, time-multiplexed fully-connected neuron for the ECG classifier layers.
//  - Consumes one activation per beat over a valid/ready stream.
//  - Multiply-accumulates against a run-time loadable weight/bias register file.
//  - Applies optional ReLU, Q-format rescale and saturation, then emits one result per frame.
//  - Replaces fixed fan-in, fixed-weight parallel nodes: one multiplier per neuron, any fan-in.

---
 rtl/fc_neuron_seq_mac.sv | 143 ++++++++++++++
 1 files changed

// File: rtl/fc_neuron_seq_mac.sv
// Time-multiplexed fully-connected neuron: one multiplier, run-time loadable weights/bias,
// per-frame ReLU / Q-format rescale / saturation over valid/ready streams.
module fc_neuron_seq_mac #(
    parameter int N_IN   = 15,
    parameter int DATA_W = 16,
    parameter int W_W    = 16,
    parameter int ACC_W  = 40,
    parameter int FRAC   = 13,
    parameter int OUT_W  = 16,
    parameter int RELU   = 1
) (
    input  logic                             clk,
    input  logic                             reset,
    input  logic                             cfg_we,
    input  logic [$clog2(N_IN+1)-1:0]        cfg_addr,
    input  logic signed [W_W-1:0]            cfg_wdata,
    input  logic                             s_valid,
    output logic                             s_ready,
    input  logic signed [DATA_W-1:0]         s_data,
    input  logic                             s_last,
    output logic                             m_valid,
    input  logic                             m_ready,
    output logic signed [OUT_W-1:0]          m_data,
    output logic                             m_sat,
    output logic                             err_len
);

    localparam int AW = $clog2(N_IN + 1);
    localparam int IW = $clog2(N_IN);
    localparam int PW = DATA_W + W_W;
    localparam logic [IW-1:0] LAST_IDX = IW'(N_IN - 1);
    localparam logic signed [ACC_W-1:0] OUT_MAX = {{(ACC_W-OUT_W+1){1'b0}}, {(OUT_W-1){1'b1}}};
    localparam logic signed [ACC_W-1:0] OUT_MIN = {{(ACC_W-OUT_W+1){1'b1}}, {(OUT_W-1){1'b0}}};

    typedef enum logic [1:0] {
        ST_ACCUM  = 2'd0,
        ST_FINISH = 2'd1,
        ST_OUT    = 2'd2
    } state_t;

    state_t state, state_next;

    logic signed [W_W-1:0]   w_mem [N_IN];
    logic signed [W_W-1:0]   bias;
    logic [IW-1:0]           idx;
    logic signed [ACC_W-1:0] acc;
    logic signed [PW-1:0]    prod;
    logic signed [ACC_W-1:0] prod_ext;
    logic signed [ACC_W-1:0] bias_ext;
    logic signed [ACC_W-1:0] sh;
    logic signed [OUT_W-1:0] res_data;
    logic                    res_sat;
    logic                    beat;
    logic                    is_last;

    // ---------------- FSM ----------------
    // NOTE: sequential state uses non-blocking assignments so every register sees pre-edge values.
    always_ff @(posedge clk) begin
        if (reset) state <= ST_ACCUM;
        else       state <= state_next;
    end

    always_comb begin
        // NOTE: every combinational output gets a default first, so no path can infer a latch.
        state_next = state;
        case (state)
            ST_ACCUM:  if (beat && is_last) state_next = ST_FINISH;
            ST_FINISH: state_next = ST_OUT;
            ST_OUT:    if (m_ready) state_next = ST_ACCUM;
            default:   state_next = ST_ACCUM;
        endcase
    end

    always_comb begin
        s_ready = (state == ST_ACCUM);
        m_valid = (state == ST_OUT);
    end

    assign beat    = s_valid & s_ready;
    assign is_last = (idx == LAST_IDX);

    // ---------------- weight / bias register file ----------------
    // NOTE: the weight file must read as zero after reset, so it is built from resettable flops, not a RAM.
    always_ff @(posedge clk) begin
        if (reset) begin
            for (int i = 0; i < N_IN; i++) w_mem[i] <= '0;
            bias <= '0;
        end else if (cfg_we) begin
            for (int i = 0; i < N_IN; i++)
                if (cfg_addr == AW'(i)) w_mem[i] <= cfg_wdata;
            if (cfg_addr == AW'(N_IN)) bias <= cfg_wdata;
        end
    end

    // ---------------- datapath ----------------
    assign prod     = s_data * w_mem[idx];
    assign prod_ext = {{(ACC_W-PW){prod[PW-1]}}, prod};
    assign bias_ext = {{(ACC_W-W_W){bias[W_W-1]}}, bias};

    // Bias is folded in with the first product of a frame, so a bias write after that beat
    // only reaches the following frame.
    always_ff @(posedge clk) begin
        if (reset) begin
            idx     <= '0;
            acc     <= '0;
            err_len <= 1'b0;
            m_data  <= '0;
            m_sat   <= 1'b0;
        end else begin
            if (beat) begin
                acc <= ((idx == '0) ? bias_ext : acc) + prod_ext;
                idx <= is_last ? '0 : idx + IW'(1);
                if (s_last != is_last) err_len <= 1'b1;
            end
            if (state == ST_FINISH) begin
                m_data <= res_data;
                m_sat  <= res_sat;
            end
            if (state == ST_OUT && m_ready) begin
                idx <= '0;
                acc <= '0;
            end
        end
    end

    // Rescale from the weight Q-format, then rectify or clip into the output range.
    assign sh = acc >>> FRAC;

    always_comb begin
        res_data = sh[OUT_W-1:0];
        res_sat  = 1'b0;
        if (RELU != 0 && acc[ACC_W-1]) begin
            res_data = '0;
        end else if (sh > OUT_MAX) begin
            res_data = OUT_MAX[OUT_W-1:0];
            res_sat  = 1'b1;
        end else if (RELU == 0 && sh < OUT_MIN) begin
            res_data = OUT_MIN[OUT_W-1:0];
            res_sat  = 1'b1;
        end
    end

endmodule
